// File: rtl/request_unit_atomic.sv
// request_unit_atomic: per-core memory request sequencer with LL/SC link tracking and stall counter
//
// Sequences an instruction fetch followed by an optional data access. Each data access is a
// multi-cycle handshake: the PC is stalled while the access waits for dhit, and a sticky halt
// is latched when a HALT instruction is fetched.
//
// Build option: define REQ_UNIT_ATOMIC_EN to enable the LL/SC link register, snoop
// invalidation, datomic and sc_success. Without it, LL is a plain read, SC is a plain
// write that is always issued, datomic is 0 and sc_success is 1.
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   ihit, dhit           instruction / data access complete this cycle
//   halt_in              decoded instruction is HALT
//   mem_read, mem_write  decoded load / store (store wins if both are set)
//   ll_in, sc_in         load-linked / store-conditional qualifiers
//   mem_addr, mem_store  effective address and store data
//   snoop_valid/addr     write by another master, used to invalidate the link
//   iREN, dREN, dWEN     bus enables, decoded from state
//   datomic              current data access is LL or SC
//   dmemaddr, dmemstore  latched address and store data, stable during DATA
//   pc_en                PC/pipeline may advance this cycle
//   sc_success           result of the most recent SC
//   cpu_halt             sticky halt
//   stall_cnt            saturating count of cycles spent in DATA
module request_unit_atomic #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              halt_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ll_in,
    input  logic              sc_in,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_store,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              datomic,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              pc_en,
    output logic              sc_success,
    output logic              cpu_halt,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {IDLE, DATA, HALT} state_t;

    state_t state, state_n;
    logic   op_wr;
    logic   sc_fail;
    logic   take;

    always_comb begin
        state_n = state;
        pc_en   = 1'b0;
        case (state)
            IDLE: if (ihit) begin
                if (halt_in)
                    state_n = HALT;
                else if ((mem_read | mem_write) && !sc_fail)
                    state_n = DATA;
                else
                    pc_en = 1'b1;
            end
            DATA: if (dhit) begin
                pc_en   = 1'b1;
                state_n = IDLE;
            end
            default: ;
        endcase
        if (RST)
            pc_en = 1'b0;
    end

    assign take = (state == IDLE) && (state_n == DATA);
    assign iREN = (state == IDLE) && !RST;
    assign dREN = (state == DATA) && !op_wr;
    assign dWEN = (state == DATA) && op_wr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            cpu_halt  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                dmemaddr  <= mem_addr;
                dmemstore <= mem_store;
                op_wr     <= mem_write;
            end
            if (state_n == HALT)
                cpu_halt <= 1'b1;
            if (state == DATA && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef REQ_UNIT_ATOMIC_EN
    logic              link_valid;
    logic [ADDR_W-3:0] link_addr;
    logic              op_ll;
    logic              op_sc;
    logic              data_done;

    // SC is judged against the link as registered, so a snoop in the same cycle cannot fail it
    assign sc_fail   = mem_write && sc_in &&
                       !(link_valid && mem_addr[ADDR_W-1:2] == link_addr);
    assign data_done = (state == DATA) && dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
            op_ll      <= 1'b0;
            op_sc      <= 1'b0;
            datomic    <= 1'b0;
            sc_success <= 1'b0;
        end else begin
            if (take) begin
                op_ll   <= mem_read & ll_in & ~mem_write;
                op_sc   <= mem_write & sc_in;
                datomic <= (mem_read & ll_in & ~mem_write) | (mem_write & sc_in);
            end else if (data_done) begin
                datomic <= 1'b0;
            end
            // a snoop to the word being linked in the same cycle leaves the link invalid
            if (data_done && op_ll) begin
                link_addr  <= dmemaddr[ADDR_W-1:2];
                link_valid <= !(snoop_valid && snoop_addr[ADDR_W-1:2] == dmemaddr[ADDR_W-1:2]);
            end else if (data_done && op_sc) begin
                link_valid <= 1'b0;
                sc_success <= 1'b1;
            end else if (state == IDLE && ihit && !halt_in && sc_fail) begin
                link_valid <= 1'b0;
                sc_success <= 1'b0;
            end else if (snoop_valid && snoop_addr[ADDR_W-1:2] == link_addr) begin
                link_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_atomic;

    assign unused_atomic = ^{ll_in, sc_in, snoop_valid, snoop_addr};
    assign sc_fail       = 1'b0;
    assign datomic       = 1'b0;
    assign sc_success    = 1'b1;
`endif

endmodule
